// File: rtl/piano_pkg.sv
// Shared constants and types for the piano key encoder.
// Note codes are 1..9 for keys 0..8; 0 means no key pressed.
package piano_pkg;

    localparam int NUM_KEYS = 9;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_1    = 4'd1;
    localparam logic [3:0] NOTE_2    = 4'd2;
    localparam logic [3:0] NOTE_3    = 4'd3;
    localparam logic [3:0] NOTE_4    = 4'd4;
    localparam logic [3:0] NOTE_5    = 4'd5;
    localparam logic [3:0] NOTE_6    = 4'd6;
    localparam logic [3:0] NOTE_7    = 4'd7;
    localparam logic [3:0] NOTE_8    = 4'd8;
    localparam logic [3:0] NOTE_9    = 4'd9;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// One key: multi-flop synchronizer, stability counter and debounced state.
// The debounced state is kept in the same active-low sense as the input.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   state_n_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign pressed = ~state_n_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            cnt_q     <= '0;
            state_n_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
            if (synced == state_n_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                // Input has differed for DEBOUNCE_CYCLES cycles: accept it
                state_n_q <= synced;
                cnt_q     <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_encoder.sv
// Debounced 9-key piano encoder: lowest pressed key wins, registered
// 4-bit note code plus note_on / note_off strobes from a 2-state FSM.
module key_encoder
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic                p0,
    output logic                p1,
    output logic                p2,
    output logic                p3,
    output logic                note_valid,
    output logic                note_on,
    output logic                note_off
);

    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] lowest;
    logic [3:0]          code_d;
    logic [3:0]          code_q;
    state_t              state_q;
    state_t              state_d;
    logic                on_d;
    logic                off_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .key_n  (key_n[i]),
            .pressed(pressed[i])
        );
    end

    // Isolate the lowest set bit so the decoder below sees at most one hot
    assign lowest = pressed & (~pressed + NUM_KEYS'(1));

    always_comb begin
        code_d = NOTE_NONE;
        unique case (1'b1)
            lowest[0]: code_d = NOTE_1;
            lowest[1]: code_d = NOTE_2;
            lowest[2]: code_d = NOTE_3;
            lowest[3]: code_d = NOTE_4;
            lowest[4]: code_d = NOTE_5;
            lowest[5]: code_d = NOTE_6;
            lowest[6]: code_d = NOTE_7;
            lowest[7]: code_d = NOTE_8;
            lowest[8]: code_d = NOTE_9;
            default:   code_d = NOTE_NONE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        on_d    = 1'b0;
        off_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (code_d != NOTE_NONE) begin
                    state_d = PLAYING;
                    on_d    = 1'b1;
                end
            end
            PLAYING: begin
                if (code_d == NOTE_NONE) begin
                    state_d = IDLE;
                    off_d   = 1'b1;
                end else if (code_d != code_q) begin
                    on_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= NOTE_NONE;
            note_valid <= 1'b0;
            note_on    <= 1'b0;
            note_off   <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            note_valid <= (code_d != NOTE_NONE);
            note_on    <= on_d;
            note_off   <= off_d;
        end
    end

    assign p0 = code_q[0];
    assign p1 = code_q[1];
    assign p2 = code_q[2];
    assign p3 = code_q[3];

endmodule
